// File: rtl/audio_stream_vol_bridge_if.sv
// Frame stream bundle between the HPS FIFO side and the codec side.
// slave: bridge view (sinks in_*, drives out_*); master: opposite.
interface audio_stream_vol_bridge_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16
);
    localparam int FW = CHANNELS * SAMPLE_W;

    logic          in_valid;
    logic [FW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [FW-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/audio_stream_vol_bridge.sv
// Frame FIFO that primes, then replays frames on sample_tick with
// per-channel saturating volume and a saturating underrun counter.
// Ports: clk_clk/reset_reset_n; st (in_valid/in_data/in_ready,
// out_valid/out_data); play; vol/vol_set/vol_flag; sample_tick;
// level (frames stored); underrun_cnt.
module audio_stream_vol_bridge #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 64,
    parameter int VOL_W    = 7
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    audio_stream_vol_bridge_if.slave  st,
    input  logic                      play,
    input  logic [CHANNELS*VOL_W-1:0] vol,
    input  logic                      vol_set,
    output logic                      vol_flag,
    input  logic                      sample_tick,
    output logic [$clog2(DEPTH):0]    level,
    output logic [15:0]               underrun_cnt
);
    localparam int FW = CHANNELS * SAMPLE_W;
    localparam int VW = CHANNELS * VOL_W;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = SAMPLE_W + VOL_W + 1;

    localparam logic [VOL_W-1:0] UNITY =
        {1'b1, {(VOL_W-1){1'b0}}};
    localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [FW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic flush;
    logic busy;
    logic tick_acc;
    logic copy;

    logic [VW-1:0] vol_act;
    logic [VW-1:0] vol_pend;
    logic          pend_v;

    logic          s1_v;
    logic [FW-1:0] s1_data;
    logic [VW-1:0] s1_vol;
    logic [FW-1:0] scaled;
    logic          out_v;
    logic [FW-1:0] out_q;

    assign full  = (cnt == FULL);
    assign empty = (cnt == '0);

    assign st.in_ready = (state_q != IDLE) & ~full;
    assign push        = st.in_valid & st.in_ready;

    // A tick is only honoured once the previous frame has left
    // both pipeline stages.
    assign busy     = s1_v | out_v;
    assign tick_acc = sample_tick & ~busy & (state_q == RUN);
    assign pop      = tick_acc & ~empty;
    assign flush    = ~play | (state_q == IDLE);

    // A vol_set landing on the boundary defers the copy so the
    // newest request is never overtaken by an older one.
    assign copy = pend_v & ~vol_set &
                  ((state_q != RUN) | tick_acc);

    assign vol_flag     = copy;
    assign level        = cnt;
    assign st.out_valid = out_v;
    assign st.out_data  = out_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (play) state_d = PRIME;
            end
            PRIME: begin
                if (!play)            state_d = IDLE;
                else if (cnt >= HALF) state_d = RUN;
            end
            RUN: begin
                if (!play)                 state_d = IDLE;
                else if (tick_acc & empty) state_d = PRIME;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr] <= st.in_data;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            vol_act  <= {CHANNELS{UNITY}};
            vol_pend <= {CHANNELS{UNITY}};
            pend_v   <= 1'b0;
        end else if (vol_set) begin
            vol_pend <= vol;
            pend_v   <= 1'b1;
        end else if (copy) begin
            vol_act <= vol_pend;
            pend_v  <= 1'b0;
        end
    end

    // Stage 1: latch the frame (zero on underrun) and its gain.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_vol  <= {CHANNELS{UNITY}};
        end else begin
            s1_v <= tick_acc;
            if (tick_acc) begin
                s1_data <= pop ? mem[rd_ptr] : '0;
                s1_vol  <= copy ? vol_pend : vol_act;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic signed [PW-1:0] SMAX =
            {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
        localparam logic signed [PW-1:0] SMIN =
            {{(PW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

        logic signed [SAMPLE_W-1:0] smp;
        logic signed [VOL_W:0]      gain;
        logic signed [PW-1:0]       prod;
        logic signed [PW-1:0]       shr;
        logic        [SAMPLE_W-1:0] sat;

        assign smp  = s1_data[c*SAMPLE_W +: SAMPLE_W];
        assign gain = {1'b0, s1_vol[c*VOL_W +: VOL_W]};
        assign prod = PW'(smp) * PW'(gain);
        assign shr  = prod >>> (VOL_W - 1);

        always_comb begin
            sat = shr[SAMPLE_W-1:0];
            if (shr > SMAX)      sat = SMAX[SAMPLE_W-1:0];
            else if (shr < SMIN) sat = SMIN[SAMPLE_W-1:0];
        end

        assign scaled[c*SAMPLE_W +: SAMPLE_W] = sat;
    end

    // Stage 2: register the saturated result and strobe it out.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_v <= 1'b0;
            out_q <= '0;
        end else begin
            out_v <= s1_v;
            if (s1_v) out_q <= scaled;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            underrun_cnt <= '0;
        end else if (tick_acc & empty &
                     (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_audio_stream_vol_bridge.sv
// Randomised bench for audio_stream_vol_bridge against a
// queue-based reference model of the frame bridge.
module tb_audio_stream_vol_bridge;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play = 1'b0;
    logic [13:0] vol = '0;
    logic        vol_set = 1'b0;
    logic        vol_flag;
    logic        sample_tick = 1'b0;
    logic [6:0]  level;
    logic [15:0] underrun_cnt;

    audio_stream_vol_bridge_if #(.CHANNELS(2), .SAMPLE_W(16)) st();

    audio_stream_vol_bridge #(
        .CHANNELS(2), .SAMPLE_W(16), .DEPTH(DEPTH), .VOL_W(7)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .st           (st),
        .play         (play),
        .vol          (vol),
        .vol_set      (vol_set),
        .vol_flag     (vol_flag),
        .sample_tick  (sample_tick),
        .level        (level),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_PRIME, M_RUN} mode_e;
    typedef struct {
        int          due;
        logic [31:0] data;
    } sched_t;

    mode_e       mode;
    logic [31:0] fifo_q[$];
    sched_t      pipe_q[$];
    int          cyc = 0;
    int          since;
    int          m_under;
    logic [13:0] m_act;
    logic [13:0] m_pend;
    bit          m_has_pend;
    logic [31:0] m_out;
    bit          m_ov;

    function automatic logic [31:0] scale(logic [31:0] f,
                                          logic [13:0] v);
        logic [31:0] res;
        res = '0;
        for (int c = 0; c < 2; c++) begin
            int s;
            int g;
            int r;
            s = $signed(f[c*16 +: 16]);
            g = int'(v[c*7 +: 7]);
            r = (s * g) >>> 6;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            res[c*16 +: 16] = r[15:0];
        end
        return res;
    endfunction

    function automatic bit tick_ok();
        return sample_tick && mode == M_RUN && since >= 3;
    endfunction

    function automatic bit m_copy();
        return m_has_pend && !vol_set &&
               (mode != M_RUN || tick_ok());
    endfunction

    task automatic model_reset();
        fifo_q.delete();
        pipe_q.delete();
        mode = M_IDLE;
        since = 3;
        m_under = 0;
        m_act = {7'd64, 7'd64};
        m_pend = {7'd64, 7'd64};
        m_has_pend = 0;
        m_out = '0;
        m_ov = 0;
    endtask

    always @(posedge clk) begin : mdl
        bit          tk;
        bit          cp;
        bit          pu;
        int          sz;
        logic [31:0] d;
        if (!rst_n) begin
            model_reset();
        end else begin
            tk = tick_ok();
            cp = m_copy();
            sz = fifo_q.size();
            pu = st.in_valid && mode != M_IDLE && sz < DEPTH;
            if (tk) begin
                if (sz > 0) begin
                    d = fifo_q.pop_front();
                end else begin
                    d = '0;
                    if (m_under < 65535) m_under++;
                end
                pipe_q.push_back('{due: cyc + 2,
                    data: scale(d, cp ? m_pend : m_act)});
            end
            if (pu) fifo_q.push_back(st.in_data);
            if (!play || mode == M_IDLE) fifo_q.delete();
            case (mode)
                M_IDLE:  if (play) mode = M_PRIME;
                M_PRIME: if (!play) mode = M_IDLE;
                         else if (sz >= DEPTH / 2) mode = M_RUN;
                default: if (!play) mode = M_IDLE;
                         else if (tk && sz == 0) mode = M_PRIME;
            endcase
            if (vol_set) begin
                m_pend = vol;
                m_has_pend = 1;
            end else if (cp) begin
                m_act = m_pend;
                m_has_pend = 0;
            end
            since = tk ? 1 : (since < 3 ? since + 1 : since);
            cyc++;
            m_ov = 0;
            if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
                m_ov = 1;
                m_out = pipe_q[0].data;
                void'(pipe_q.pop_front());
            end
        end
    end

    task automatic cmp_all();
        check("in_ready", st.in_ready,
              mode != M_IDLE && fifo_q.size() < DEPTH);
        check("vol_flag", vol_flag, m_copy());
        check("out_valid", st.out_valid, m_ov);
        check("out_data", st.out_data, m_out);
        check("level", level, fifo_q.size());
        check("underrun", underrun_cnt, m_under);
    endtask

    // ---------------- stimulus helpers ----------------
    bit nxt_play = 0;

    task automatic cyc_drive(bit iv, logic [31:0] d, bit tk,
                             bit vs, logic [13:0] v);
        @(negedge clk);
        play = nxt_play;
        st.in_valid = iv;
        st.in_data = d;
        sample_tick = tk;
        vol_set = vs;
        if (vs) vol = v;
        #1 cmp_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc_drive(0, '0, 0, 0, '0);
    endtask

    task automatic do_tick(bit vs, logic [13:0] v);
        cyc_drive(0, '0, 1, vs, v);
        idle(2);
    endtask

    function automatic logic [31:0] rnd_frame();
        logic [31:0] f;
        f = $urandom();
        case ($urandom_range(0, 5))
            0: f[15:0] = 16'h7FFF;
            1: f[31:16] = 16'h8000;
            default: ;
        endcase
        return f;
    endfunction

    task automatic soak(int n, int p_play);
        int gap;
        gap = 0;
        for (int i = 0; i < n; i++) begin
            bit tk;
            bit vs;
            logic [13:0] v;
            if ($urandom_range(0, 99) >= p_play)
                nxt_play = ~nxt_play;
            else
                nxt_play = 1;
            tk = (gap == 0);
            if (tk) gap = $urandom_range(1, 6);
            else gap--;
            vs = ($urandom_range(0, 49) == 0);
            v = $urandom();
            if ($urandom_range(0, 3) == 0) v[6:0] = 7'd127;
            cyc_drive($urandom_range(0, 9) < 6, rnd_frame(),
                      tk, vs, v);
        end
        nxt_play = 1;
    endtask

    localparam logic [31:0] F1  = 32'hFC18_03E8;
    localparam logic [31:0] F30 = 32'h7530_7530;

    initial begin
        st.in_valid = 0;
        st.in_data = '0;
        model_reset();
        idle(3);
        check("rst_out_data", st.out_data, 32'h0);
        check("rst_level", level, 7'd0);
        rst_n = 1'b1;
        idle(2);

        // Prime with 32 constant frames, then replay at unity.
        nxt_play = 1;
        idle(1);
        for (int i = 0; i < 32; i++) cyc_drive(1, F1, 0, 0, '0);
        idle(2);
        for (int i = 0; i < 6; i++) do_tick(0, '0);
        check("t1_data", st.out_data, F1);

        // Volume change on a tick boundary.
        for (int i = 0; i < 10; i++) cyc_drive(1, F30, 0, 0, '0);
        for (int i = 0; i < 26; i++) do_tick(0, '0);
        do_tick(1, {7'd0, 7'd127});
        check("t2_unity", st.out_data, F30);
        cyc_drive(0, '0, 1, 0, '0);
        check("t2_flag", vol_flag, 1'b1);
        idle(2);
        check("t2_sat", st.out_data, 32'h0000_7FFF);
        do_tick(1, {7'd64, 7'd64});
        idle(1);

        // Fill to full with no ticks.
        for (int i = 0; i < 70; i++)
            cyc_drive(1, rnd_frame(), 0, 0, '0);
        check("t3_full_lvl", level, 7'd64);
        check("t3_full_rdy", st.in_ready, 1'b0);
        cyc_drive(1, rnd_frame(), 1, 0, '0);
        cyc_drive(1, rnd_frame(), 0, 0, '0);
        check("t3_pop_lvl", level, 7'd63);
        check("t3_pop_rdy", st.in_ready, 1'b1);
        cyc_drive(1, rnd_frame(), 0, 0, '0);
        check("t3_refill", level, 7'd64);

        // Drain to empty, then one underrun tick.
        for (int i = 0; i < 80 && fifo_q.size() > 0; i++)
            do_tick(0, '0);
        check("t4_drained", fifo_q.size() == 0, 1'b1);
        do_tick(0, '0);
        check("t4_out0", st.out_data, 32'h0);
        check("t4_under", underrun_cnt, 16'd1);
        do_tick(0, '0);
        for (int i = 0; i < 31; i++)
            cyc_drive(1, rnd_frame(), 0, 0, '0);
        do_tick(0, '0);
        check("t4_no_play", underrun_cnt, 16'd1);
        cyc_drive(1, rnd_frame(), 0, 0, '0);
        idle(2);
        do_tick(0, '0);

        // Stop with frames stored and one in flight.
        for (int i = 0; i < 40 && fifo_q.size() > 20; i++)
            do_tick(0, '0);
        check("t5_lvl20", level, 7'd20);
        cyc_drive(0, '0, 1, 0, '0);
        nxt_play = 0;
        idle(2);
        check("t5_ov", st.out_valid, 1'b1);
        check("t5_lvl0", level, 7'd0);
        check("t5_rdy0", st.in_ready, 1'b0);
        check("t5_under", underrun_cnt, 16'd1);
        idle(2);

        // Random traffic.
        nxt_play = 1;
        soak(1500, 97);

        // Reset during the multiply stage.
        nxt_play = 1;
        idle(1);
        for (int i = 0; i < 40; i++)
            cyc_drive(1, rnd_frame(), 0, 0, '0);
        idle(2);
        cyc_drive(0, '0, 1, 1, {7'd5, 7'd9});
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 cmp_all();
        check("t6_out0", st.out_data, 32'h0);
        check("t6_lvl0", level, 7'd0);
        idle(3);
        check("t6_ov0", st.out_valid, 1'b0);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 34; i++)
            cyc_drive(1, 32'hC000_2000, 0, 0, '0);
        idle(2);
        do_tick(0, '0);
        check("t6_unity", st.out_data, 32'hC000_2000);

        soak(2000, 98);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
